// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: 16x oversampling with 3-sample majority vote, followed by a
// small circular FIFO drained through the rdy/rdy_clr handshake.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       rx,
  output logic       rdy,
  input  logic       rdy_clr,
  output logic [7:0] dout,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr
);

  localparam int OS_DIV = CLK_HZ / (BAUD * 16);
  localparam int CW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int NW     = AW + 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BRK   = 3'd4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic          rx_meta;
  logic          rx_s;
  logic [1:0]    fill;
  logic          armed;
  logic [2:0]    state;
  logic [CW-1:0] os_cnt;
  logic          tick;
  logic [3:0]    smp;
  logic [2:0]    bit_idx;
  logic          v7;
  logic          v8;
  logic [7:0]    shreg;
  logic          maj;
  logic          push_req;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr_n;
  logic [NW-1:0] count;
  logic [NW-1:0] count_n;
  logic          pop_ok;
  logic          push_ok;
  logic          ovr_set;
  logic [7:0]    head_n;

  // Synchronizer; armed only once the line has been seen idle after reset,
  // so a line held low across reset release cannot start a frame.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      fill    <= 2'b00;
      armed   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      fill    <= {fill[0], 1'b1};
      armed   <= armed | (fill[1] & rx_s);
    end
  end

  assign tick     = (state != ST_IDLE) && (os_cnt == CW'(OS_DIV - 1));
  assign maj      = maj3(v7, v8, rx_s);
  assign push_req = tick && (state == ST_STOP) && (smp == 4'd9) && maj;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      os_cnt <= '0;
    end else if (state == ST_IDLE || os_cnt == CW'(OS_DIV - 1)) begin
      os_cnt <= '0;
    end else begin
      os_cnt <= os_cnt + CW'(1);
    end
  end

  // Bit-level sequencing: vote at sample 9, bit boundary at sample 15
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      smp       <= 4'd0;
      bit_idx   <= 3'd0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (armed && !rx_s) begin
            smp   <= 4'd0;
            state <= ST_START;
          end
        end
        ST_BRK: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: begin
          if (tick) begin
            smp <= smp + 4'd1;
            if (smp == 4'd9) begin
              if (state == ST_START && maj) begin
                state <= ST_IDLE;
              end else if (state == ST_STOP) begin
                if (maj) begin
                  state <= ST_IDLE;
                end else begin
                  frame_err <= 1'b1;
                  state     <= ST_BRK;
                end
              end
            end
            if (smp == 4'd15) begin
              if (state == ST_START) begin
                state   <= ST_DATA;
                bit_idx <= 3'd0;
              end else if (state == ST_DATA) begin
                if (bit_idx == 3'd7) state <= ST_STOP;
                else                 bit_idx <= bit_idx + 3'd1;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_50m) begin
    if (tick) begin
      if (smp == 4'd7) v7 <= rx_s;
      if (smp == 4'd8) v8 <= rx_s;
      if (state == ST_DATA && smp == 4'd9) shreg <= {maj, shreg[7:1]};
    end
  end

  // FIFO: a pop frees the slot first, so a push into a full FIFO with a pop is kept
  assign pop_ok  = rdy_clr && (count != '0);
  assign push_ok = push_req && ((count != NW'(FIFO_DEPTH)) || pop_ok);
  assign ovr_set = push_req && !push_ok;
  assign rptr_n  = pop_ok ? rptr + AW'(1) : rptr;
  assign head_n  = (push_ok && rptr_n == wptr) ? shreg : mem[rptr_n];
  assign rdy     = (count != '0);

  always_comb begin
    count_n = count;
    if (push_ok && !pop_ok)      count_n = count + NW'(1);
    else if (!push_ok && pop_ok) count_n = count - NW'(1);
  end

  always_ff @(posedge clk_50m) begin
    if (push_ok) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      rptr    <= '0;
      wptr    <= '0;
      count   <= '0;
      dout    <= 8'h00;
      overrun <= 1'b0;
    end else begin
      rptr  <= rptr_n;
      count <= count_n;
      if (push_ok)         wptr <= wptr + AW'(1);
      if (count_n != '0)   dout <= head_n;
      if (ovr_set)         overrun <= 1'b1;
      else if (err_clr)    overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized scoreboard bench for uart_rx_fifo: a serial driver feeds frames, a
// queue-style model holds the bytes the FIFO should deliver, a monitor pops and compares.
module tb_uart_rx_fifo;

  localparam int OS    = 4;
  localparam int BIT   = OS * 16;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rdy;
  logic       rdy_clr;
  logic [7:0] dout;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;

  uart_rx_fifo #(.CLK_HZ(50_000_000), .BAUD(781_250), .FIFO_DEPTH(DEPTH)) dut (
    .clk_50m(clk), .rst(rst), .rx(rx), .rdy(rdy), .rdy_clr(rdy_clr),
    .dout(dout), .frame_err(frame_err), .overrun(overrun), .err_clr(err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_mem [0:255];
  int  wr_idx    = 0;
  int  rd_idx    = 0;
  bit  auto_pop  = 1'b0;
  int  pops_req  = 0;
  int  pops_done = 0;
  int  pop_at    = -1;
  bit  arm_pop   = 1'b0;
  int  t_start   = 0;
  bit  exp_ovr   = 1'b0;
  int  vec_m = 0, err_m = 0;
  int  vec_s = 0, err_s = 0;
  int  ferr_cnt = 0;

  // Monitor: owns rdy_clr, pops the model whenever it pops the DUT
  initial begin
    rdy_clr = 1'b0;
    forever begin
      @(negedge clk);
      rdy_clr = 1'b0;
      if (rst) begin
        rd_idx = wr_idx;
      end else begin
        if (frame_err) ferr_cnt++;
        if (rdy && (auto_pop || pops_req > pops_done || cyc == pop_at)) begin
          if (!auto_pop && pops_req > pops_done) pops_done++;
          vec_s++;
          if (rd_idx == wr_idx) begin
            err_s++;
            $display("FAIL unexpected_byte: dout=0x%02h but no byte expected", dout);
          end else begin
            if (dout !== exp_mem[rd_idx % 256]) begin
              err_s++;
              $display("FAIL byte_%0d: dout=0x%02h expected 0x%02h", rd_idx, dout, exp_mem[rd_idx % 256]);
            end
            rd_idx++;
          end
          rdy_clr = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vec_m++;
    if (act != exp) begin
      err_m++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic void model_push(input logic [7:0] b);
    if (wr_idx - rd_idx < DEPTH) begin
      exp_mem[wr_idx % 256] = b;
      wr_idx++;
    end else begin
      exp_ovr = 1'b1;
    end
  endfunction

  task automatic send_frame(input logic [7:0] b, input int bclk, input logic stop,
                            input int stop_bits, input bit expect_it);
    @(negedge clk);
    rx = 1'b0;
    t_start = cyc;
    if (arm_pop) pop_at = t_start + OS * 154 + 2;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bclk) @(negedge clk);
    end
    rx = stop;
    if (expect_it && stop) model_push(b);
    repeat (bclk * stop_bits) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < BIT * 12 && rd_idx != wr_idx; i++) @(negedge clk);
    check(name, wr_idx - rd_idx, 0);
  endtask

  task automatic manual_pops(input int n, input string name);
    pops_req += n;
    for (int i = 0; i < 200 && pops_done != pops_req; i++) @(negedge clk);
    check(name, pops_req - pops_done, 0);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int ferr0;
    rst = 1'b1;
    rx = 1'b1;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rdy", rdy, 0);
    check("reset_dout", dout, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // 1: single byte, latency and pop
    auto_pop = 1'b0;
    lat = -1;
    fork
      send_frame(8'h55, BIT, 1'b1, 1, 1'b1);
      begin
        for (int i = 0; i < BIT * 12; i++) begin
          @(negedge clk);
          if (rdy) begin
            lat = cyc - t_start;
            break;
          end
        end
      end
    join
    check("rdy_latency_ok", (lat >= OS * 154 && lat <= OS * 154 + 6) ? 1 : 0, 1);
    check("dout_55", dout, 8'h55);
    manual_pops(1, "pop_55");
    check("rdy_after_pop", rdy, 0);

    // 2: glitch rejected, then a real byte
    auto_pop = 1'b1;
    ferr0 = ferr_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (BIT * 2) @(negedge clk);
    check("glitch_rdy", rdy, 0);
    check("glitch_ferr", ferr_cnt, ferr0);
    send_frame(8'hA3, BIT, 1'b1, 1, 1'b1);
    drain("drain_a3");

    // 3: framing error with held-low line
    ferr0 = ferr_cnt;
    send_frame(8'hA5, BIT, 1'b0, 2, 1'b1);
    repeat (4) @(negedge clk);
    check("ferr_once", ferr_cnt, ferr0 + 1);
    check("ferr_no_rdy", rdy, 0);
    send_frame(8'h3C, BIT, 1'b1, 1, 1'b1);
    drain("drain_3c");

    // 4: overrun
    auto_pop = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), BIT, 1'b1, 1, 1'b1);
    check("overrun_set", overrun, exp_ovr);
    manual_pops(4, "pops_overrun");
    check("empty_after_4", rdy, 0);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    exp_ovr = 1'b0;
    check("overrun_cleared", overrun, 0);

    // 5: pop on the exact push cycle of a full FIFO
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), BIT, 1'b1, 1, 1'b1);
    check("full_rdy", rdy, 1);
    arm_pop = 1'b1;
    send_frame(8'h77, BIT, 1'b1, 1, 1'b0);
    arm_pop = 1'b0;
    pop_at = -1;
    model_push(8'h77);
    check("no_overrun_on_pop_push", overrun, 0);
    check("model_full", wr_idx - rd_idx, 4);
    manual_pops(4, "pops_full");
    check("empty_after_77", rdy, 0);

    // 6: reset mid-frame
    send_frame(8'h99, BIT, 1'b1, 1, 1'b1);
    check("held_99", rdy, 1);
    fork
      send_frame(8'hF0, BIT, 1'b1, 1, 1'b0);
      begin
        repeat (1 + BIT * 5 + BIT / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rdy", rdy, 0);
        check("midrst_dout", dout, 0);
        check("midrst_ferr", frame_err, 0);
        check("midrst_overrun", overrun, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (BIT) @(negedge clk);
    check("no_byte_after_rst", rdy, 0);
    auto_pop = 1'b1;
    send_frame(8'h0F, BIT, 1'b1, 1, 1'b1);
    drain("drain_0f");

    ferr0 = ferr_cnt;
    for (int i = 0; i < 20; i++)
      send_frame(8'($urandom_range(0, 255)), int'($urandom_range(BIT - 1, BIT + 1)), 1'b1, 1, 1'b1);
    drain("drain_random");
    check("random_no_ferr", ferr_cnt, ferr0);
    check("random_no_overrun", overrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_m + vec_s, err_m + err_s);
    $finish;
  end

endmodule
